// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program counter.
package pc_pkg;

    localparam int unsigned DEFAULT_XLEN = 32;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    // Next-PC selector; codes 6 and 7 fall back to sequential fetch
    typedef enum logic [2:0] {
        PC_SEQ    = 3'd0,
        PC_JALR   = 3'd1,
        PC_BRANCH = 3'd2,
        PC_JAL    = 3'd3,
        PC_TRAP   = 3'd4,
        PC_MRET   = 3'd5
    } pc_src_e;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } pc_state_e;

    // Number of low address bits that must be zero for a legal target
    function automatic int unsigned align_bits(input int unsigned ialign);
        return (ialign == 2) ? 1 : 2;
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection: picks the candidate target, applies the
// JALR/trap masking and flags targets that violate instruction alignment.
module pc_next_mux
    import pc_pkg::*;
#(
    parameter int unsigned XLEN   = DEFAULT_XLEN,
    parameter int unsigned IALIGN = 4
) (
    input  logic [XLEN-1:0] pc,
    input  logic [2:0]      pc_source,
    input  logic [XLEN-1:0] jalr,
    input  logic [XLEN-1:0] branch,
    input  logic [XLEN-1:0] jal,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc_inc,
    output logic            redirect,
    output logic            misaligned
);

    localparam int unsigned ALIGN_BITS = align_bits(IALIGN);
    localparam logic [XLEN-1:0] STEP = XLEN'(IALIGN);
    localparam logic [XLEN-1:0] KEEP_MASK = {{(XLEN-ALIGN_BITS){1'b1}}, {ALIGN_BITS{1'b0}}};

    pc_src_e src;
    logic    check_align;

    assign src    = pc_src_e'(pc_source);
    assign pc_inc = pc + STEP;

    // Select the candidate target; the trap vector is forced aligned, while
    // jump, branch and return targets are checked instead of being fixed up
    always_comb begin
        target      = pc_inc;
        redirect    = 1'b0;
        check_align = 1'b0;
        case (src)
            PC_JALR: begin
                target      = {jalr[XLEN-1:1], 1'b0};
                redirect    = 1'b1;
                check_align = 1'b1;
            end
            PC_BRANCH: begin
                target      = branch;
                redirect    = 1'b1;
                check_align = 1'b1;
            end
            PC_JAL: begin
                target      = jal;
                redirect    = 1'b1;
                check_align = 1'b1;
            end
            PC_TRAP: begin
                target      = mtvec & KEEP_MASK;
                redirect    = 1'b1;
            end
            PC_MRET: begin
                target      = mepc;
                redirect    = 1'b1;
                check_align = 1'b1;
            end
            default: begin
                target      = pc_inc;
            end
        endcase
    end

    assign misaligned = check_align && ((target & ~KEEP_MASK) != '0);

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage program counter: boots from the reset vector, advances on
// accepted fetches, applies redirects and parks them while fetch is stalled.
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int unsigned XLEN         = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int unsigned IALIGN       = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_write,
    input  logic [2:0]      pc_source,
    input  logic [XLEN-1:0] jalr,
    input  logic [XLEN-1:0] branch,
    input  logic [XLEN-1:0] jal,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_out_inc,
    output logic            fetch_valid,
    output logic            redirect_pending,
    output logic            misalign,
    output logic [XLEN-1:0] misalign_addr
);

    pc_state_e       state;
    pc_state_e       state_next;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] pend_q;
    logic [XLEN-1:0] pend_next;
    logic            fetch_valid_q;
    logic            fetch_valid_next;
    logic            misalign_q;
    logic            misalign_next;
    logic [XLEN-1:0] misalign_addr_q;
    logic [XLEN-1:0] misalign_addr_next;

    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_inc;
    logic            redirect;
    logic            misaligned;
    logic            adv;
    logic            good_redirect;

    pc_next_mux #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) u_next_mux (
        .pc         (pc_q),
        .pc_source  (pc_source),
        .jalr       (jalr),
        .branch     (branch),
        .jal        (jal),
        .mtvec      (mtvec),
        .mepc       (mepc),
        .target     (target),
        .pc_inc     (pc_inc),
        .redirect   (redirect),
        .misaligned (misaligned)
    );

    assign imem_req_valid = (state != S_BOOT);
    assign adv            = pc_write & imem_req_valid & imem_req_ready;
    assign good_redirect  = redirect & ~misaligned;

    // State register; reset drops any parked redirect and the open request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: boot lasts one cycle, unaccepted redirects park in HOLD
    always_comb begin
        state_next = state;
        case (state)
            S_BOOT: state_next = S_RUN;
            S_RUN: begin
                if (good_redirect && !adv) begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (adv && !(redirect && misaligned)) begin
                    state_next = S_RUN;
                end
            end
            default: state_next = S_BOOT;
        endcase
    end

    // Datapath updates per state; a rejected target only raises the flag
    always_comb begin
        pc_next            = pc_q;
        pend_next          = pend_q;
        fetch_valid_next   = fetch_valid_q;
        misalign_next      = 1'b0;
        misalign_addr_next = misalign_addr_q;
        case (state)
            S_RUN: begin
                if (redirect && misaligned) begin
                    misalign_next      = 1'b1;
                    misalign_addr_next = target;
                end else if (redirect) begin
                    fetch_valid_next = 1'b0;
                    if (adv) begin
                        pc_next = target;
                    end else begin
                        pend_next = target;
                    end
                end else if (adv) begin
                    pc_next          = pc_inc;
                    fetch_valid_next = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect && misaligned) begin
                    misalign_next      = 1'b1;
                    misalign_addr_next = target;
                end else begin
                    if (redirect) begin
                        pend_next = target;
                    end
                    if (adv) begin
                        pc_next          = redirect ? target : pend_q;
                        fetch_valid_next = 1'b0;
                    end
                end
            end
            default: begin
                pc_next = pc_q;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q            <= RESET_VECTOR;
            pend_q          <= '0;
            fetch_valid_q   <= 1'b0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            pc_q            <= pc_next;
            pend_q          <= pend_next;
            fetch_valid_q   <= fetch_valid_next;
            misalign_q      <= misalign_next;
            misalign_addr_q <= misalign_addr_next;
        end
    end

    assign pc_out           = pc_q;
    assign imem_addr        = pc_q;
    assign pc_out_inc       = pc_inc;
    assign fetch_valid      = fetch_valid_q;
    assign redirect_pending = (state == S_HOLD);
    assign misalign         = misalign_q;
    assign misalign_addr    = misalign_addr_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: one IALIGN=4 instance and one IALIGN=2
// instance share the same stimulus.
module tb_pc_fetch_unit;
    import pc_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        pc_write;
    logic [2:0]  pc_source;
    logic [31:0] jalr;
    logic [31:0] branch;
    logic [31:0] jal;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        imem_req_ready;

    logic        imem_req_valid;
    logic [31:0] imem_addr;
    logic [31:0] pc_out;
    logic [31:0] pc_out_inc;
    logic        fetch_valid;
    logic        redirect_pending;
    logic        misalign;
    logic [31:0] misalign_addr;

    logic        h_imem_req_valid;
    logic [31:0] h_imem_addr;
    logic [31:0] h_pc_out;
    logic [31:0] h_pc_out_inc;
    logic        h_fetch_valid;
    logic        h_redirect_pending;
    logic        h_misalign;
    logic [31:0] h_misalign_addr;

    int compare_count = 0;
    int mismatch_count = 0;

    pc_fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h100), .IALIGN(4)) dut (
        .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .pc_source(pc_source),
        .jalr(jalr), .branch(branch), .jal(jal), .mtvec(mtvec), .mepc(mepc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .pc_out(pc_out), .pc_out_inc(pc_out_inc),
        .fetch_valid(fetch_valid), .redirect_pending(redirect_pending),
        .misalign(misalign), .misalign_addr(misalign_addr)
    );

    pc_fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h100), .IALIGN(2)) dut_half (
        .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .pc_source(pc_source),
        .jalr(jalr), .branch(branch), .jal(jal), .mtvec(mtvec), .mepc(mepc),
        .imem_req_valid(h_imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(h_imem_addr), .pc_out(h_pc_out), .pc_out_inc(h_pc_out_inc),
        .fetch_valid(h_fetch_valid), .redirect_pending(h_redirect_pending),
        .misalign(h_misalign), .misalign_addr(h_misalign_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compare_count++;
        if (actual !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", tag, actual, expected);
        end
    endtask

    // Drive the selector and handshake inputs, then wait one edge and settle
    task automatic applyStimulus(input logic [2:0] src, input logic wr, input logic rdy);
        pc_source      = src;
        pc_write       = wr;
        imem_req_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        pc_write       = 1'b1;
        pc_source      = PC_SEQ;
        imem_req_ready = 1'b1;
        jalr   = '0;
        branch = '0;
        jal    = '0;
        mtvec  = '0;
        mepc   = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_pc", pc_out, 32'h100);
        checkOutput("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        checkOutput("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        checkOutput("rst_pending", {31'd0, redirect_pending}, 32'd0);
        checkOutput("rst_misalign", {31'd0, misalign}, 32'd0);
        checkOutput("rst_misalign_addr", misalign_addr, 32'd0);

        // Boot and sequential fetch
        rst_n = 1'b1;
        applyStimulus(PC_SEQ, 1'b1, 1'b1);
        checkOutput("boot_pc", pc_out, 32'h100);
        checkOutput("boot_req_valid", {31'd0, imem_req_valid}, 32'd1);
        applyStimulus(PC_SEQ, 1'b1, 1'b1);
        checkOutput("seq1_pc", pc_out, 32'h104);
        checkOutput("seq1_fetch_valid", {31'd0, fetch_valid}, 32'd1);
        checkOutput("seq1_half_pc", h_pc_out, 32'h102);
        applyStimulus(PC_SEQ, 1'b1, 1'b1);
        checkOutput("seq2_pc", pc_out, 32'h108);
        checkOutput("seq2_addr", imem_addr, 32'h108);
        checkOutput("seq2_inc", pc_out_inc, 32'h10C);

        // Branch redirect with immediate acceptance
        jal = 32'h200;
        applyStimulus(PC_JAL, 1'b1, 1'b1);
        checkOutput("jal_pc", pc_out, 32'h200);
        branch = 32'h340;
        applyStimulus(PC_BRANCH, 1'b1, 1'b1);
        checkOutput("br_pc", pc_out, 32'h340);
        checkOutput("br_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        applyStimulus(PC_SEQ, 1'b1, 1'b1);
        checkOutput("br_seq_pc", pc_out, 32'h344);
        checkOutput("br_seq_fetch_valid", {31'd0, fetch_valid}, 32'd1);

        // Stalled redirects: newest pending target wins
        jal = 32'h500;
        applyStimulus(PC_JAL, 1'b0, 1'b1);
        checkOutput("stall1_pc", pc_out, 32'h344);
        checkOutput("stall1_pending", {31'd0, redirect_pending}, 32'd1);
        checkOutput("stall1_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        branch = 32'h600;
        applyStimulus(PC_BRANCH, 1'b0, 1'b1);
        checkOutput("stall2_pending", {31'd0, redirect_pending}, 32'd1);
        applyStimulus(PC_SEQ, 1'b0, 1'b1);
        checkOutput("stall3_pc", pc_out, 32'h344);
        checkOutput("stall3_pending", {31'd0, redirect_pending}, 32'd1);
        applyStimulus(PC_SEQ, 1'b1, 1'b1);
        checkOutput("unstall_pc", pc_out, 32'h600);
        checkOutput("unstall_pending", {31'd0, redirect_pending}, 32'd0);

        // Memory not ready: address must hold
        applyStimulus(PC_SEQ, 1'b1, 1'b0);
        checkOutput("notready_addr", imem_addr, 32'h600);

        // JALR to 0x1003: legal at IALIGN=2, rejected at IALIGN=4
        jalr = 32'h0000_1003;
        applyStimulus(PC_JALR, 1'b1, 1'b1);
        checkOutput("jalr4_misalign", {31'd0, misalign}, 32'd1);
        checkOutput("jalr4_misalign_addr", misalign_addr, 32'h1002);
        checkOutput("jalr4_pc", pc_out, 32'h600);
        checkOutput("jalr2_pc", h_pc_out, 32'h1002);
        checkOutput("jalr2_misalign", {31'd0, h_misalign}, 32'd0);
        applyStimulus(PC_SEQ, 1'b1, 1'b1);
        checkOutput("after_jalr_misalign", {31'd0, misalign}, 32'd0);
        checkOutput("after_jalr_addr_held", misalign_addr, 32'h1002);
        checkOutput("after_jalr_pc", pc_out, 32'h604);

        // Trap return to an aligned and a misaligned address
        mepc = 32'h700;
        applyStimulus(PC_MRET, 1'b1, 1'b1);
        checkOutput("mret_pc", pc_out, 32'h700);
        mepc = 32'h702;
        applyStimulus(PC_MRET, 1'b1, 1'b1);
        checkOutput("mret_bad_misalign", {31'd0, misalign}, 32'd1);
        checkOutput("mret_bad_addr", misalign_addr, 32'h702);
        checkOutput("mret_bad_pc", pc_out, 32'h700);

        // Wrap-around and trap vector masking
        jal = 32'hFFFF_FFFC;
        applyStimulus(PC_JAL, 1'b1, 1'b1);
        checkOutput("wrap_pre_pc", pc_out, 32'hFFFF_FFFC);
        checkOutput("wrap_pre_inc", pc_out_inc, 32'h0);
        applyStimulus(PC_SEQ, 1'b1, 1'b1);
        checkOutput("wrap_pc", pc_out, 32'h0);
        mtvec = 32'h8000_0003;
        applyStimulus(PC_TRAP, 1'b1, 1'b1);
        checkOutput("trap4_pc", pc_out, 32'h8000_0000);
        checkOutput("trap2_pc", h_pc_out, 32'h8000_0002);

        // Asynchronous reset while a redirect is parked
        jal = 32'h900;
        applyStimulus(PC_JAL, 1'b0, 1'b1);
        checkOutput("hold_pending", {31'd0, redirect_pending}, 32'd1);
        pc_source = PC_SEQ;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_pc", pc_out, 32'h100);
        checkOutput("async_rst_pending", {31'd0, redirect_pending}, 32'd0);
        checkOutput("async_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
